regfile_writeback: RTL
======================

Name: regfile_writeback

Overview:
Write-side initiator for the register file. It collects results from the ALU and the load/store unit and queues them in a small in-order FIFO. It drains one entry per cycle onto the register file's single write port (write_index/write_data/write_enable). It also exposes a pending-write mask and youngest-entry forwarding so decode can see results that are not yet committed.

Parameters:
XLEN, 32, data width
DEPTH, 4, queue entries; power of two, at least 2
REG_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
i_mem_valid  in  1  load result valid
o_mem_ready  out  1  load result accepted
i_mem_rd  in  REG_W  load destination
i_mem_data  in  XLEN  load data
i_alu_valid  in  1  ALU result valid
o_alu_ready  out  1  ALU result accepted
i_alu_rd  in  REG_W  ALU destination
i_alu_data  in  XLEN  ALU data
o_write_enable  out  1  to register file write enable
o_write_index  out  REG_W  to register file write index
o_write_data  out  XLEN  to register file write data
i_read_index1, i_read_index2  in  REG_W  decode source indices
o_fwd_hit1, o_fwd_hit2  out  1  queued value exists for that index
o_fwd_data1, o_fwd_data2  out  XLEN  youngest queued value
o_pending  out  2**REG_W  bit i set if a write to xi is queued
o_count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- Reset:
  - Pointers and count clear; all entries are invalidated.
  - While rst=1: o_write_enable=0, o_mem_ready=0, o_alu_ready=0, o_pending=0, o_fwd_hit*=0, o_count=0.
  - Reset mid-operation drops all queued writes. No write is emitted in the reset cycle or afterwards for those entries.
- Space is computed from the registered count at the start of the cycle. A same-cycle pop is ignored when computing space.
- Handshakes:
  - o_mem_ready = free>=1.
  - o_alu_ready = free >= 1 + i_mem_valid.
  - A transfer occurs on valid&ready at the rising edge. Ready is combinational from valid; valid has no dependency on ready.
- Push order within a cycle: mem entry first (older), then ALU entry. Up to 2 pushes per cycle.
- rd=0 handling:
  - The handshake completes and the entry is discarded: not enqueued, no count change, no pending bit.
  - The reservation rule is unchanged, so rd=0 still counts in the o_alu_ready computation.
- Drain:
  - o_write_enable = !empty && !rst; o_write_index/o_write_data = head entry (combinational from storage).
  - The head pops at the same edge the register file captures it. Latency: accepted at edge N, presented during cycle N+1, architecturally visible after edge N+1.
- Count next value: count + pushes − pop. It never exceeds DEPTH. Pointers wrap mod DEPTH.
- Forwarding:
  - o_fwd_hitk = (i_read_indexk != 0) && any valid entry (head included) has rd == i_read_indexk.
  - o_fwd_datak = data of the youngest matching entry; 0 when there is no hit.
  - Same-cycle incoming sources are not forwarded.
- o_pending: OR over valid entries of the one-hot rd; bit 0 is always 0.

Decomposition:
- Package regfile_wb_pkg holds:
  - XLEN and REG_W constants;
  - typedef wb_entry_t {logic [REG_W-1:0] rd; logic [XLEN-1:0] data;}.
- Sub-module writeback_queue: DEPTH-entry circular buffer with 0–2 pushes and 0–1 pop per cycle. It exports the entry array, valid vector and age order for the forwarding/pending logic.
- Top regfile_writeback: handshakes, rd=0 filter, forwarding priority search, pending mask.

Test Plan:
1. Reset, then ALU rd=1 0xDEADBEEF for one cycle.
   - Next cycle: write_enable=1, index 1, data 0xDEADBEEF, o_pending[1]=1, count=1.
   - One cycle later: count=0, and a register_file instance reads x1=0xDEADBEEF.
2. Same cycle, mem rd=2 0x1111 and ALU rd=3 0x2222 at count=0.
   - Both accepted; count=2.
   - Write port shows x2/0x1111, then x3/0x2222 on consecutive cycles.
3. ALU rd=0 data 0xBEEF.
   - alu_ready=1; count stays 0; write_enable stays 0; o_pending=0.
   - Register file x0 reads 0.
4. Dual pushes every cycle for 6 cycles, rd=4..15, data=rd*0x10.
   - count never exceeds 4; alu_ready drops when free<2.
   - All accepted entries are written in order; none lost or duplicated.
5. Same cycle, mem rd=5 0xA and ALU rd=5 0xB, with read_index1=5 and read_index2=0.
   - Next cycle: fwd_hit1=1, fwd_data1=0xB, fwd_hit2=0.
   - After both drain: fwd_hit1=0 and register file x5=0xB.
6. With 3 entries queued, assert rst for one cycle.
   - write_enable=0 during rst; count=0 afterwards; o_pending=0.
   - No write_enable pulses follow.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared constants, queue entry type and helpers for the register-file writeback path.
package regfile_wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int WB_DEPTH = 4;
    localparam int NUM_REGS = 2 ** REG_W;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << rd;
    endfunction

endpackage

// File: rtl/writeback_queue.sv
// In-order circular buffer accepting up to two pushes and one pop per cycle.
// Callers must never push more entries than the free space at the start of the cycle.
module writeback_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  wb_entry_t        push0_entry,
    input  logic             push1,
    input  wb_entry_t        push1_entry,
    input  logic             pop,
    output wb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [PTR_W-1:0] age_slot [DEPTH],
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    wb_entry_t        entries_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] slot1_s;
    logic [CNT_W-1:0] push_n_s;
    logic             pop_s;
    logic             empty_s;

    // Slot selection: a lone push1 lands at the tail, otherwise right behind push0.
    always_comb begin
        empty_s  = (count_r == {CNT_W{1'b0}});
        slot1_s  = push0 ? (tail_r + PTR_W'(1)) : tail_r;
        push_n_s = CNT_W'(push0) + CNT_W'(push1);
        pop_s    = pop && !empty_s;
    end

    // Pointer, occupancy and valid-bit state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_W'(1);
            end
            if (push0) begin
                valid_r[tail_r] <= 1'b1;
            end
            if (push1) begin
                valid_r[slot1_s] <= 1'b1;
            end
            tail_r  <= tail_r + PTR_W'(push_n_s);
            count_r <= count_r + push_n_s - CNT_W'(pop_s);
        end
    end

    // Entry payload storage; contents only matter where valid_r is set.
    always_ff @(posedge clk) begin
        if (push0) begin
            entries_r[tail_r] <= push0_entry;
        end
        if (push1) begin
            entries_r[slot1_s] <= push1_entry;
        end
    end

    // Physical slot of each entry by age, oldest (head) first.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_slot[k] = head_r + PTR_W'(k);
        end
    end

    assign entries = entries_r;
    assign valid   = valid_r;
    assign count   = count_r;
    assign empty   = empty_s;

endmodule

// File: rtl/regfile_writeback.sv
// Collects ALU and load results, queues them in order and drains one per cycle to the
// register file write port, exposing pending writes and youngest-value forwarding to decode.
module regfile_writeback
    import regfile_wb_pkg::*;
#(
    parameter int XLEN_W  = XLEN,
    parameter int DEPTH   = WB_DEPTH,
    parameter int INDEX_W = REG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_valid,
    output logic                  o_mem_ready,
    input  logic [INDEX_W-1:0]    i_mem_rd,
    input  logic [XLEN_W-1:0]     i_mem_data,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [INDEX_W-1:0]    i_alu_rd,
    input  logic [XLEN_W-1:0]     i_alu_data,
    output logic                  o_write_enable,
    output logic [INDEX_W-1:0]    o_write_index,
    output logic [XLEN_W-1:0]     o_write_data,
    input  logic [INDEX_W-1:0]    i_read_index1,
    input  logic [INDEX_W-1:0]    i_read_index2,
    output logic                  o_fwd_hit1,
    output logic                  o_fwd_hit2,
    output logic [XLEN_W-1:0]     o_fwd_data1,
    output logic [XLEN_W-1:0]     o_fwd_data2,
    output logic [2**INDEX_W-1:0] o_pending,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wb_entry_t        entries_s [DEPTH];
    logic [DEPTH-1:0] valid_s;
    logic [PTR_W-1:0] age_s [DEPTH];
    logic [CNT_W-1:0] count_s;
    logic             empty_s;

    logic [CNT_W-1:0] free_s;
    logic             mem_ready_s;
    logic             alu_ready_s;
    logic             push0_s;
    logic             push1_s;
    logic             we_s;
    wb_entry_t        mem_entry_s;
    wb_entry_t        alu_entry_s;

    logic                m1_s;
    logic                m2_s;
    logic                hit1_s;
    logic                hit2_s;
    logic [XLEN_W-1:0]   data1_s;
    logic [XLEN_W-1:0]   data2_s;
    logic [NUM_REGS-1:0] pending_s;

    function automatic logic fwd_match(input logic v, input logic [INDEX_W-1:0] rd,
                                       input logic [INDEX_W-1:0] idx);
        return v && (rd == idx) && (idx != {INDEX_W{1'b0}});
    endfunction

    // Handshakes: space comes from the start-of-cycle count, and the ALU slot is reserved
    // behind a valid load even when either result targets x0 and is then dropped.
    always_comb begin
        free_s      = DEPTH_C - count_s;
        mem_ready_s = !rst && (free_s >= CNT_W'(1));
        alu_ready_s = !rst && (free_s >= (CNT_W'(1) + CNT_W'(i_mem_valid)));
        push0_s     = i_mem_valid && mem_ready_s && (i_mem_rd != {INDEX_W{1'b0}});
        push1_s     = i_alu_valid && alu_ready_s && (i_alu_rd != {INDEX_W{1'b0}});
        we_s        = !empty_s && !rst;
        mem_entry_s = '{rd: i_mem_rd, data: i_mem_data};
        alu_entry_s = '{rd: i_alu_rd, data: i_alu_data};
    end

    writeback_queue #(.DEPTH(DEPTH)) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push0       (push0_s),
        .push0_entry (mem_entry_s),
        .push1       (push1_s),
        .push1_entry (alu_entry_s),
        .pop         (we_s),
        .entries     (entries_s),
        .valid       (valid_s),
        .age_slot    (age_s),
        .count       (count_s),
        .empty       (empty_s)
    );

    // Forwarding walks oldest to youngest so the last match wins.
    always_comb begin
        m1_s    = 1'b0;
        m2_s    = 1'b0;
        hit1_s  = 1'b0;
        hit2_s  = 1'b0;
        data1_s = {XLEN_W{1'b0}};
        data2_s = {XLEN_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            m1_s    = fwd_match(valid_s[age_s[k]], entries_s[age_s[k]].rd, i_read_index1);
            m2_s    = fwd_match(valid_s[age_s[k]], entries_s[age_s[k]].rd, i_read_index2);
            hit1_s  = hit1_s | m1_s;
            hit2_s  = hit2_s | m2_s;
            data1_s = m1_s ? entries_s[age_s[k]].data : data1_s;
            data2_s = m2_s ? entries_s[age_s[k]].data : data2_s;
        end
    end

    // Pending-write mask over queued destinations; x0 never appears.
    always_comb begin
        pending_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s | (valid_s[i] ? rd_onehot(entries_s[i].rd) : {NUM_REGS{1'b0}});
        end
        pending_s[0] = 1'b0;
    end

    assign o_mem_ready    = mem_ready_s;
    assign o_alu_ready    = alu_ready_s;
    assign o_write_enable = we_s;
    assign o_write_index  = entries_s[age_s[0]].rd;
    assign o_write_data   = entries_s[age_s[0]].data;
    assign o_fwd_hit1     = hit1_s && !rst;
    assign o_fwd_hit2     = hit2_s && !rst;
    assign o_fwd_data1    = rst ? {XLEN_W{1'b0}} : data1_s;
    assign o_fwd_data2    = rst ? {XLEN_W{1'b0}} : data2_s;
    assign o_pending      = rst ? {NUM_REGS{1'b0}} : pending_s;
    assign o_count        = rst ? {CNT_W{1'b0}} : count_s;

endmodule
